// File: rtl/sw_led_mmio.sv
// Memory-mapped LED register and debounced switch port (LED, switches, change status, reserved).
// Latency: one cycle for reads/writes (rdy and rdata in cycle N+1); no stall; optional debouncer under `SW_DEBOUNCE_EN.
module sw_led_mmio #(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter int          DEB_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdy,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR
);

    logic [15:0] offset;
    logic        hit;
    logic        wr_acc;
    logic        rd_acc;
    logic        clr_status;
    logic [15:0] rd_sel;

    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [9:0]  sw_stable;
    logic        stable_chg;
    logic        status;

    assign offset     = addr - BASE_ADDR;
    assign hit        = (offset < 16'd4);
    assign wr_acc     = hit && we;
    // A simultaneous write takes precedence, so the read half is dropped.
    assign rd_acc     = hit && re && !we;
    assign clr_status = rd_acc && (offset[1:0] == 2'd2);

    always_comb begin
        rd_sel = 16'h0000;
        case (offset[1:0])
            2'd0:    rd_sel = {6'b0, LEDR};
            2'd1:    rd_sel = {6'b0, sw_stable};
            2'd2:    rd_sel = {15'b0, status};
            default: rd_sel = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LEDR  <= 10'd0;
            rdata <= 16'h0000;
            rdy   <= 1'b0;
        end else begin
            rdy <= wr_acc || rd_acc;
            if (wr_acc && offset[1:0] == 2'd0)
                LEDR <= wdata[9:0];
            if (rd_acc)
                rdata <= rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 10'd0;
            sw_sync <= 10'd0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

`ifdef SW_DEBOUNCE_EN
    logic [7:0] deb_cnt;
    logic [7:0] deb_cnt_inc;

    assign deb_cnt_inc = deb_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt    <= 8'd0;
            sw_stable  <= 10'd0;
            stable_chg <= 1'b0;
        end else begin
            stable_chg <= 1'b0;
            if (sw_sync == sw_stable) begin
                deb_cnt <= 8'd0;
            end else if (deb_cnt_inc == 8'(DEB_CNT)) begin
                sw_stable  <= sw_sync;
                deb_cnt    <= 8'd0;
                stable_chg <= 1'b1;
            end else begin
                deb_cnt <= deb_cnt_inc;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_stable  <= 10'd0;
            stable_chg <= 1'b0;
        end else begin
            sw_stable  <= sw_sync;
            stable_chg <= (sw_sync != sw_stable);
        end
    end
`endif

    // Set beats clear when a change lands on the same cycle as a status read.
    always_ff @(posedge clk) begin
        if (rst)
            status <= 1'b0;
        else
            status <= stable_chg || (status && !clr_status);
    end

endmodule

// File: tb/tb_sw_led_mmio.sv
// Directed bench for sw_led_mmio with DEB_CNT=4; expectations adapt to SW_DEBOUNCE_EN.
module tb_sw_led_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;
    logic [9:0]  SW;
    logic [9:0]  LEDR;

    int checks   = 0;
    int failures = 0;

    sw_led_mmio #(.BASE_ADDR(16'hC000), .DEB_CNT(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we), .wdata(wdata),
        .rdata(rdata), .rdy(rdy), .SW(SW), .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic exp_rdy);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        tick();
        check("wr_rdy", {15'b0, rdy}, {15'b0, exp_rdy});
        we = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] a, input logic [15:0] exp,
                            input logic exp_rdy);
        addr = a; re = 1'b1; we = 1'b0;
        tick();
        check({tag, "_rdy"}, {15'b0, rdy}, {15'b0, exp_rdy});
        check(tag, rdata, exp);
        re = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 16'h0; re = 1'b0; we = 1'b0; wdata = 16'h0; SW = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ledr", {6'b0, LEDR}, 16'h0);
            check("rst_rdy", {15'b0, rdy}, 16'h0);
        end
        check("rst_rdata", rdata, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_rdy", {15'b0, rdy}, 16'h0);
            check("post_rst_ledr", {6'b0, LEDR}, 16'h0);
        end
`ifdef SW_DEBOUNCE_EN
        bus_read("sw_early", 16'hC001, 16'h0000, 1'b1);
`else
        bus_read("sw_early", 16'hC001, 16'h02A5, 1'b1);
`endif
        bus_read("sw_after_rst", 16'hC001, 16'h02A5, 1'b1);
        bus_read("status_set", 16'hC002, 16'h0001, 1'b1);
        bus_read("status_clr", 16'hC002, 16'h0000, 1'b1);

        bus_write(16'hC000, 16'hFFFF, 1'b1);
        check("ledr_ffff", {6'b0, LEDR}, 16'h03FF);
        bus_read("led_read", 16'hC000, 16'h03FF, 1'b1);
        tick();
        check("rdy_one_cycle", {15'b0, rdy}, 16'h0);

`ifdef SW_DEBOUNCE_EN
        SW = 10'h2A4;
        repeat (3) tick();
        SW = 10'h2A5;
        repeat (10) tick();
        bus_read("bounce_sw", 16'hC001, 16'h02A5, 1'b1);
        bus_read("bounce_status", 16'hC002, 16'h0000, 1'b1);
`endif

        SW = 10'h2A4;
        repeat (10) tick();
        bus_read("chg_sw", 16'hC001, 16'h02A4, 1'b1);
        bus_read("chg_status1", 16'hC002, 16'h0001, 1'b1);
        bus_read("chg_status2", 16'hC002, 16'h0000, 1'b1);

        bus_read("led_again", 16'hC000, 16'h03FF, 1'b1);
        addr = 16'hC000; wdata = 16'h0155; we = 1'b1; re = 1'b1;
        tick();
        check("both_rdy", {15'b0, rdy}, 16'h1);
        check("both_ledr", {6'b0, LEDR}, 16'h0155);
        check("both_rdata", rdata, 16'h03FF);
        we = 1'b0; re = 1'b0;
        tick();
        check("both_single_rdy", {15'b0, rdy}, 16'h0);

        bus_write(16'hC004, 16'h0000, 1'b0);
        check("undec_wr_ledr", {6'b0, LEDR}, 16'h0155);
        bus_read("undec_rd", 16'hBFFF, 16'h03FF, 1'b0);

        bus_write(16'hC003, 16'h03FF, 1'b1);
        check("rsvd_wr_ledr", {6'b0, LEDR}, 16'h0155);
        bus_read("rsvd_rd", 16'hC003, 16'h0000, 1'b1);

        bus_write(16'hC000, 16'h0012, 1'b1);
        bus_write(16'hC000, 16'h0034, 1'b1);
        check("b2b_ledr", {6'b0, LEDR}, 16'h0034);

        rst = 1'b1;
        bus_write(16'hC000, 16'h00AA, 1'b0);
        check("rst_drop_ledr", {6'b0, LEDR}, 16'h0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
